serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: diff = a - b - bin, processed LSB first, one bit per clock.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/full_subtractor_bit.sv | 13 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = x - y - c, nb = borrow out.
module full_subtractor_bit (
   input  logic x,
   input  logic y,
   input  logic c,
   output logic d,
   output logic nb
);

   assign d  = x ^ y ^ c;
   assign nb = (~x & y) | (~x & c) | (y & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, valid/ready on both sides.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; a producer holds valid and its data stable until that edge.

   localparam int CW = cnt_w(WIDTH);

   sub_state_t       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] diff_sh;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             nb_bit;
   logic             last_bit;

   full_subtractor_bit u_cell (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .c  (borrow),
      .d  (d_bit),
      .nb (nb_bit)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
   // Borrow into the MSB; overflow when it differs from the borrow out of the MSB.
   logic msb_bin;
   assign ovf = msb_bin ^ bout;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         diff_sh   <= '0;
         borrow    <= 1'b0;
         cnt       <= '0;
`ifdef SERIAL_SUB_OVF_EN
         msb_bin   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  borrow   <= bin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               borrow  <= nb_bit;
               cnt     <= cnt + CW'(1);
               if (last_bit) begin
                  // Publish the finished word directly so diff/bout are valid with out_valid.
                  diff      <= {d_bit, diff_sh[WIDTH-1:1]};
                  bout      <= nb_bit;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  msb_bin   <= borrow;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8), directed cases plus random traffic.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         bin_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf_o;

   int tests_run;
   int tests_failed;

   // expected {ovf, bout, diff}
   logic [W+1:0] exp_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .bin       (bin_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf       (ovf_o)
`endif
   );

`ifndef SERIAL_SUB_OVF_EN
   assign ovf_o = 1'b0;
`endif

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference model: plain integer arithmetic on the operand values
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
      int unsigned ua;
      int unsigned ub;
      int          sa;
      int          sb;
      int          sd;
      logic [W-1:0] d;
      logic        bo;
      logic        ov;
      ua = a;
      ub = b;
      sa = (a[W-1]) ? int'(ua) - (1 << W) : int'(ua);
      sb = (b[W-1]) ? int'(ub) - (1 << W) : int'(ub);
      d  = W'((ua + (1 << W) - ub - bin) % (1 << W));
      bo = (ua < ub + bin);
      sd = sa - sb - int'(bin);
      ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
      return {ov, bo, d};
   endfunction

   // drivers
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input string name);
      logic hs;
      int   n;
      a_i = a;
      b_i = b;
      bin_i = bin;
      in_valid = 1'b1;
      hs = 1'b0;
      n = 0;
      while (!hs && n < 60) begin
         hs = in_ready;
         step();
         n++;
      end
      in_valid = 1'b0;
      if (!hs) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s accept_timeout in_ready=%0b required=1", name, in_ready);
      end
   endtask

   task automatic wait_valid(output int n, input string name);
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      if (!out_valid) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s out_valid_timeout after %0d cycles", name, n);
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input string name);
      logic [W+1:0] e;
      int           n;
      e = model(a, b, bin);
      out_ready = 1'b0;
      send_op(a, b, bin, name);
      wait_valid(n, name);
      tests_run++;
      if ({bout, diff} !== e[W:0]) begin
         tests_failed++;
         $display("FAIL %s result got bout=%0b diff=%02h required bout=%0b diff=%02h",
                  name, bout, diff, e[W], e[W-1:0]);
      end
`ifdef SERIAL_SUB_OVF_EN
      tests_run++;
      if (ovf_o !== e[W+1]) begin
         tests_failed++;
         $display("FAIL %s ovf got=%0b required=%0b", name, ovf_o, e[W+1]);
      end
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s post_handshake out_valid=%0b in_ready=%0b required 0/1",
                  name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a_i = '0;
      b_i = '0;
      bin_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 ||
          ovf_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_values in_ready=%0b out_valid=%0b diff=%02h bout=%0b ovf=%0b required 1/0/00/0/0",
                  in_ready, out_valid, diff, bout, ovf_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_latency();
      int n;
      out_ready = 1'b0;
      send_op(8'h05, 8'h03, 1'b0, "t1");
      wait_valid(n, "t1");
      tests_run++;
      if (n !== 8) begin
         tests_failed++;
         $display("FAIL t1_latency got=%0d cycles required=8", n);
      end
      tests_run++;
      if (diff !== 8'h02 || bout !== 1'b0) begin
         tests_failed++;
         $display("FAIL t1_result got diff=%02h bout=%0b required diff=02 bout=0", diff, bout);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL t1_out_valid_drop got=%0b required=0", out_valid);
      end
   endtask

   task automatic test_directed();
      run_op(8'h03, 8'h05, 1'b0, "t2");
      run_op(8'h00, 8'h00, 1'b1, "t3_zero_bin");
      run_op(8'hFF, 8'hFF, 1'b0, "t3_ff_ff");
      run_op(8'h80, 8'h01, 1'b0, "t6_80_01");
      run_op(8'h7F, 8'hFF, 1'b0, "t6_7f_ff");
      run_op(8'h05, 8'h03, 1'b0, "t6_05_03");
   endtask

   task automatic test_backpressure();
      int           n;
      logic [W-1:0] d0;
      logic         b0;
      logic [W+1:0] e;
      out_ready = 1'b0;
      send_op(8'hA5, 8'h5A, 1'b1, "t4");
      wait_valid(n, "t4");
      d0 = diff;
      b0 = bout;
      e = model(8'hA5, 8'h5A, 1'b1);
      tests_run++;
      if ({b0, d0} !== e[W:0]) begin
         tests_failed++;
         $display("FAIL t4_result got bout=%0b diff=%02h required bout=%0b diff=%02h",
                  b0, d0, e[W], e[W-1:0]);
      end
      // offer a new operand while the result is stalled
      a_i = 8'h10;
      b_i = 8'h01;
      bin_i = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if (out_valid !== 1'b1 || diff !== d0 || bout !== b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_hold cycle %0d out_valid=%0b diff=%02h bout=%0b in_ready=%0b required 1/%02h/%0b/0",
                     i, out_valid, diff, bout, in_ready, d0, b0);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL t4_after_handshake in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
      end
      step();
      in_valid = 1'b0;
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL t4_pending_accept in_ready=%0b required=0", in_ready);
      end
      wait_valid(n, "t4b");
      tests_run++;
      if (diff !== 8'h0F || bout !== 1'b0) begin
         tests_failed++;
         $display("FAIL t4b_result got diff=%02h bout=%0b required diff=0f bout=0", diff, bout);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      send_op(8'h33, 8'h11, 1'b0, "t5");
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL t5_async_reset out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         step();
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_discarded out_valid=%0b required=0", out_valid);
         end
      end
      run_op(8'h10, 8'h01, 1'b0, "t5_next");
   endtask

   task automatic test_back_to_back();
      int           sent;
      int           got;
      int           cyc;
      logic         acc;
      logic         ohs;
      logic [W+1:0] e;
      sent = 0;
      got = 0;
      cyc = 0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      while ((sent < 40 || exp_q.size() > 0) && cyc < 5000) begin
         if (!in_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
            a_i = W'($urandom);
            b_i = W'($urandom);
            bin_i = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         acc = in_valid && in_ready;
         ohs = out_valid && out_ready;
         if (ohs) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL rand_spurious_result diff=%02h bout=%0b", diff, bout);
            end else begin
               e = exp_q.pop_front();
               got++;
               if ({ovf_o, bout, diff} !== {(e[W+1] & ovf_check()), e[W:0]}) begin
                  tests_failed++;
                  $display("FAIL rand_result %0d got ovf=%0b bout=%0b diff=%02h required ovf=%0b bout=%0b diff=%02h",
                           got, ovf_o, bout, diff, e[W+1] & ovf_check(), e[W], e[W-1:0]);
               end
            end
         end
         if (acc) begin
            exp_q.push_back(model(a_i, b_i, bin_i));
            sent++;
         end
         step();
         if (acc) in_valid = 1'b0;
         cyc++;
      end
      out_ready = 1'b0;
      tests_run++;
      if (got !== 40 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL rand_drain got=%0d results required=40 (pending %0d)", got, exp_q.size());
      end
   endtask

   function automatic logic ovf_check();
`ifdef SERIAL_SUB_OVF_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_latency();
      test_directed();
      test_backpressure();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
